// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format constants: field bit positions, NOP encoding
// and the primary opcodes decoded by control.
package mips_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] J      = 6'h02;

endpackage

// File: rtl/mips_field_split.sv
// Combinational split of a 32-bit MIPS instruction into its R/I/J fields.
// Shared by the IF/ID and ID/EX stages.
module mips_field_split
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr
);

    assign opcode = instr[OPC_HI:OPC_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign shamt  = instr[SHAMT_HI:SHAMT_LO];
    assign funct  = instr[FUNCT_HI:FUNCT_LO];
    assign imm16  = instr[IMM_HI:IMM_LO];
    assign jaddr  = instr[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register with stall/flush control and field decode.
// Define IFID_PERF_CNT_EN to add saturating stall-cycle and flush counters.
module if_id_pipeline_reg
    import mips_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc_plus4,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc_plus4,
    output logic              id_valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
`ifdef IFID_PERF_CNT_EN
    output logic [25:0]       jaddr,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`else
    output logic [25:0]       jaddr
`endif
);

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;

    // Flush squashes even while stalled, so it is tested before stall.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = RESET_INSTR;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = if_instr;
            pc_d    = if_pc_plus4;
            valid_d = if_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= RESET_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign id_instr    = instr_q;
    assign id_pc_plus4 = pc_q;
    assign id_valid    = valid_q;

    mips_field_split u_split (
        .instr  (instr_q),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm16  (imm16),
        .jaddr  (jaddr)
    );

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && !flush && stall_cycles_q != 32'hFFFFFFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (flush && flush_count_q != 32'hFFFFFFFF)
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Directed self-checking bench for if_id_pipeline_reg.
// Counter checks are compiled in when IFID_PERF_CNT_EN is defined.
module tb_if_id_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_pipeline_reg dut (
        .clk         (clk),
        .rst         (rst),
        .if_instr    (if_instr),
        .if_pc_plus4 (if_pc_plus4),
        .if_valid    (if_valid),
        .stall       (stall),
        .flush       (flush),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
`ifdef IFID_PERF_CNT_EN
        .jaddr       (jaddr),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`else
        .jaddr       (jaddr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        if_instr    = ins;
        if_pc_plus4 = pc;
        if_valid    = v;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(32'hDEADBEEF, 32'h12345678, 1'b1);
        step();
        step();
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc", id_pc_plus4, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_imm16", {16'b0, imm16}, 32'h0);
        rst = 1'b0;

        // lw $2,-4($1)
        drive(32'h8C22FFFC, 32'h00400004, 1'b1);
        step();
        check("lw_opcode", {26'b0, opcode}, 32'h23);
        check("lw_rs", {27'b0, rs}, 32'd1);
        check("lw_rt", {27'b0, rt}, 32'd2);
        check("lw_rd", {27'b0, rd}, 32'd31);
        check("lw_shamt", {27'b0, shamt}, 32'd31);
        check("lw_funct", {26'b0, funct}, 32'h3C);
        check("lw_imm16", {16'b0, imm16}, 32'h0000FFFC);
        check("lw_jaddr", {6'b0, jaddr}, 32'h0022FFFC);
        check("lw_pc", id_pc_plus4, 32'h00400004);
        check("lw_valid", {31'b0, id_valid}, 32'h1);

        // Stall three edges while fetch presents the add.
        stall = 1'b1;
        drive(32'h00851020, 32'h00400008, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_instr", i), id_instr, 32'h8C22FFFC);
            check($sformatf("stall%0d_pc", i), id_pc_plus4, 32'h00400004);
        end
        stall = 1'b0;
        step();
        check("add_opcode", {26'b0, opcode}, 32'h0);
        check("add_rs", {27'b0, rs}, 32'd4);
        check("add_rt", {27'b0, rt}, 32'd5);
        check("add_rd", {27'b0, rd}, 32'd2);
        check("add_shamt", {27'b0, shamt}, 32'd0);
        check("add_funct", {26'b0, funct}, 32'h20);
        check("add_pc", id_pc_plus4, 32'h00400008);

        // Flush wins over a simultaneous stall.
        stall = 1'b1; flush = 1'b1;
        drive(32'h8C22FFFC, 32'h0040000C, 1'b1);
        step();
        check("sflush_instr", id_instr, 32'h0);
        check("sflush_pc", id_pc_plus4, 32'h0);
        check("sflush_valid", {31'b0, id_valid}, 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Invalid slot still captures instruction and PC.
        drive(32'h1000FFFF, 32'h00400010, 1'b0);
        step();
        check("inv_instr", id_instr, 32'h1000FFFF);
        check("inv_pc", id_pc_plus4, 32'h00400010);
        check("inv_valid", {31'b0, id_valid}, 32'h0);
        check("inv_opcode", {26'b0, opcode}, 32'h04);

        // Plain flush after a valid load.
        drive(32'h08000040, 32'h00400014, 1'b1);
        step();
        check("j_jaddr", {6'b0, jaddr}, 32'h00000040);
        check("j_valid", {31'b0, id_valid}, 32'h1);
        flush = 1'b1;
        step();
        check("flush_instr", id_instr, 32'h0);
        check("flush_valid", {31'b0, id_valid}, 32'h0);
        flush = 1'b0;

        // Reset during a stall still clears the register.
        drive(32'hAC430008, 32'h00400018, 1'b1);
        step();
        check("sw_opcode", {26'b0, opcode}, 32'h2B);
        stall = 1'b1; rst = 1'b1;
        step();
        check("rststall_instr", id_instr, 32'h0);
        check("rststall_pc", id_pc_plus4, 32'h0);
        check("rststall_valid", {31'b0, id_valid}, 32'h0);
        stall = 1'b0; rst = 1'b0;

`ifdef IFID_PERF_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perf_rst_stall", stall_cycles, 32'd0);
        check("perf_rst_flush", flush_count, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        stall = 1'b0;
        step();
        flush = 1'b0;
        step();
        check("perf_stall_cycles", stall_cycles, 32'd4);
        check("perf_flush_count", flush_count, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perf_clr_stall", stall_cycles, 32'd0);
        check("perf_clr_flush", flush_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipeline_reg.md
Name: if_id_pipeline_reg

Overview:
- IF/ID pipeline register of the MIPS datapath.
- Captures the fetched instruction and PC+4 each cycle, under stall/flush control.
- Splits the held instruction into its fields.
- imm16 drives the 16-bit `value` input of sign_extend directly; rs/rt feed the register file; opcode/funct feed control.

Parameters:
- DATA_W, 32, width of instruction and PC words; only 32 is supported.
- RESET_INSTR, 32'h00000000, instruction loaded on reset and flush (MIPS NOP, sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- if_instr  input  32  instruction word from instruction memory
- if_pc_plus4  input  32  PC+4 from fetch
- if_valid  input  1  fetch slot holds a real instruction
- stall  input  1  hazard unit: hold current contents
- flush  input  1  branch/jump taken: squash current contents
- id_instr  output  32  held instruction
- id_pc_plus4  output  32  held PC+4
- id_valid  output  1  held slot is a real instruction
- opcode  output  6  id_instr[31:26]
- rs  output  5  id_instr[25:21]
- rt  output  5  id_instr[20:16]
- rd  output  5  id_instr[15:11]
- shamt  output  5  id_instr[10:6]
- funct  output  6  id_instr[5:0]
- imm16  output  16  id_instr[15:0], to sign_extend.value
- jaddr  output  26  id_instr[25:0]

Behaviour:
- State: instr_q, pc_q, valid_q. All updates on the rising edge of clk only; no async paths.
- Per-edge priority: rst > flush > stall > load.
  - rst=1: instr_q=RESET_INSTR, pc_q=0, valid_q=0.
  - flush=1: same values as rst. Flush overrides a simultaneous stall.
  - stall=1, flush=0: all state held unchanged. if_valid is ignored.
  - Otherwise: instr_q=if_instr, pc_q=if_pc_plus4, valid_q=if_valid.
- A flush must also squash while stalled. A stall+flush cycle leaves a NOP with valid=0.
- if_valid=0 on load still captures if_instr and if_pc_plus4. Downstream qualifies with id_valid.
- Latency: exactly 1 cycle from the IF inputs to the id_* outputs.
- Field outputs are purely combinational slices of instr_q. No registered copies, no extra latency.
- After reset, imm16=16'h0000, so sign_extend outputs 32'h00000000.
- Reset asserted mid-stall takes effect on the next edge regardless of stall.
- No internal state machine beyond the valid bit.
- No X on any output after the first reset edge.

Optional Feature:
- IFID_PERF_CNT_EN defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each edge where stall=1, flush=0, rst=0.
  - flush_count increments each edge where flush=1, rst=0.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package mips_pkg holds:
  - Field bit-position constants (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO, JADDR_HI/LO).
  - NOP_INSTR = 32'h00000000.
  - Opcode constants R_TYPE=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, J=6'h02.
- One natural sub-module: mips_field_split. Combinational; 32-bit instruction in, the eight field outputs out. It is reused later by the ID/EX stage.

Test Plan:
- rst=1 for 2 cycles, then release -> id_instr=0, id_pc_plus4=0, id_valid=0, imm16=0.
- Load 32'h8C22FFFC (lw $2,-4($1)) with pc+4=32'h00400004, if_valid=1 -> next cycle: opcode=6'h23, rs=1, rt=2, imm16=16'hFFFC, id_pc_plus4=32'h00400004, id_valid=1. sign_extend then gives 32'hFFFFFFFC.
- Stall for 3 cycles while the IF inputs change to 32'h00851020 -> outputs stay at the lw values for all 3 cycles. Release stall -> add decoded: rs=4, rt=5, rd=2, funct=6'h20.
- Assert flush and stall together with a valid instruction held -> next cycle: id_instr=0, id_valid=0, id_pc_plus4=0.
- if_valid=0 with if_instr=32'h1000FFFF -> id_instr=32'h1000FFFF, id_valid=0.
- With IFID_PERF_CNT_EN: 5 stall cycles, 2 flushes (one overlapping a stall) -> stall_cycles=4, flush_count=2. rst then clears both to 0.
